// File: rtl/vga_line_fetch.sv
// -----------------------------------------------------------------------------
// vga_line_fetch
//
// Read-side controller between the single-port pixel BRAM and the VGA pixel
// output stage. Packed pixel words are read from the BRAM into a small word
// FIFO. Each pixel request unpacks one pixel, LSB-first, from the word at the
// head of the FIFO. The BRAM is never written: wea and dina are tied to zero.
//
// Ports
//   clk_i          system clock, same clock as the BRAM port
//   rstn_i         asynchronous active-low reset
//   frame_start_i  one-cycle pulse that restarts the frame fetch at address 0
//   pix_req_i      pixel request from the timing generator
//   rd_stall_i     BRAM port busy with the host writer; no reads are issued
//   bram_addr_o    BRAM read address
//   bram_ena_o     BRAM enable; read data is valid one cycle later
//   bram_wea_o     BRAM write enable, always 0
//   bram_dina_o    BRAM write data, always 0
//   bram_douta_i   BRAM read data
//   pix_o          pixel value, registered, one cycle after pix_req_i
//   pix_valid_o    pix_o carries a real pixel
//   underrun_o     sticky flag: a request in RUN found the FIFO empty
// -----------------------------------------------------------------------------
module vga_line_fetch #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int PIX_WIDTH    = 3,
  parameter int FRAME_WORDS  = 1024,
  parameter int FIFO_DEPTH   = 4,
  localparam int PIX_PER_WORD = RAM_WIDTH / PIX_WIDTH,
  localparam int AW           = $clog2(RAM_DEPTH - 1)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 frame_start_i,
  input  logic                 pix_req_i,
  input  logic                 rd_stall_i,
  output logic [AW-1:0]        bram_addr_o,
  output logic                 bram_ena_o,
  output logic                 bram_wea_o,
  output logic [RAM_WIDTH-1:0] bram_dina_o,
  input  logic [RAM_WIDTH-1:0] bram_douta_i,
  output logic [PIX_WIDTH-1:0] pix_o,
  output logic                 pix_valid_o,
  output logic                 underrun_o
);

  // An index register is still needed when a word holds a single pixel.
  localparam int IW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    RUN
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        addr_q;
  logic                 inflight_q;
  logic [RAM_WIDTH-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr_q;
  logic [PW-1:0]        rdPtr_q;
  logic [CW-1:0]        count_q;
  logic [IW-1:0]        idx_q;
  logic [PIX_WIDTH-1:0] pix_q;
  logic                 pixValid_q;
  logic                 underrun_q;

  logic                 issue;
  logic                 canServe;
  logic                 lastPix;
  logic                 pop;
  logic [RAM_WIDTH-1:0] headShift;
  logic [PIX_WIDTH-1:0] headPix;

  // Read issue and pixel selection. A read is issued only when the FIFO has
  // room for the word that is already in flight plus the new one. That
  // reservation is why the push path never needs a full check.
  always_comb begin
    issue     = 1'b0;
    canServe  = 1'b0;
    lastPix   = 1'b0;
    pop       = 1'b0;
    headShift = '0;
    headPix   = '0;
    if ((state_q != IDLE) && !rd_stall_i && !frame_start_i &&
        ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH)) begin
      issue = 1'b1;
    end
    canServe  = (state_q == RUN) && pix_req_i && (count_q != '0);
    lastPix   = (idx_q == IW'(PIX_PER_WORD - 1));
    pop       = canServe && lastPix;
    headShift = fifoMem_q[rdPtr_q] >> (int'(idx_q) * PIX_WIDTH);
    headPix   = headShift[PIX_WIDTH-1:0];
  end

  // FIFO storage. The word returned by the BRAM is written whenever a read
  // was in flight. A write that coincides with a flush is harmless, because
  // the flush resets the pointers and the count.
  always_ff @(posedge clk_i) begin
    if (inflight_q) begin
      fifoMem_q[wrPtr_q] <= bram_douta_i;
    end
  end

  // Control FSM, FIFO bookkeeping and the registered pixel outputs.
  // frame_start_i takes priority over everything else. It also drops a word
  // that is returning in the same cycle, by ignoring inflight_q.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      pix_q      <= '0;
      pixValid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else if (frame_start_i) begin
      state_q    <= PREFETCH;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      pix_q      <= '0;
      pixValid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        addr_q <= (addr_q == AW'(FRAME_WORDS - 1)) ? '0 : addr_q + 1'b1;
      end
      if (inflight_q) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + CW'(inflight_q) - CW'(pop);
      if ((state_q == PREFETCH) && (count_q == CW'(FIFO_DEPTH))) begin
        state_q <= RUN;
      end
      pix_q      <= '0;
      pixValid_q <= 1'b0;
      if (canServe) begin
        pix_q      <= headPix;
        pixValid_q <= 1'b1;
        idx_q      <= lastPix ? '0 : idx_q + 1'b1;
      end else if ((state_q == RUN) && pix_req_i) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign bram_addr_o = addr_q;
  assign bram_ena_o  = issue;
  assign bram_wea_o  = 1'b0;
  assign bram_dina_o = '0;
  assign pix_o       = pix_q;
  assign pix_valid_o = pixValid_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// -----------------------------------------------------------------------------
// tb_vga_line_fetch
//
// Two instances share one set of stimulus inputs. Both use FRAME_WORDS=8.
//   A: PIX_WIDTH=3, so a word holds six pixels.
//   B: PIX_WIDTH=18, so a word holds one pixel.
// Each instance has its own BRAM model with known contents. A reference model
// tracks the frame as a stream of word addresses. The FIFO is described only
// by the address of its head word and how many words it holds. Every cycle the
// model predicts the expected BRAM enable, address and pixel outputs.
// Directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_vga_line_fetch;

  localparam int FW = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fs;
  logic        req;
  logic        stall;

  logic [9:0]  addrA, addrB;
  logic        enaA, enaB, weaA, weaB;
  logic [17:0] dinaA, dinaB, doutA, doutB;
  logic [2:0]  pixA;
  logic [17:0] pixB;
  logic        validA, validB, undA, undB;

  int checks   = 0;
  int failures = 0;

  int mActive [2];
  int mRun    [2];
  int mCnt    [2];
  int mInfl   [2];
  int mNext   [2];
  int mHead   [2];
  int mIdx    [2];
  int mUnd    [2];
  int mPix    [2];
  int mValid  [2];

  always #5 clk = ~clk;

  vga_line_fetch #(
    .RAM_WIDTH(18), .RAM_DEPTH(1024), .PIX_WIDTH(3), .FRAME_WORDS(FW), .FIFO_DEPTH(4)
  ) dutA (
    .clk_i(clk), .rstn_i(rstn), .frame_start_i(fs), .pix_req_i(req), .rd_stall_i(stall),
    .bram_addr_o(addrA), .bram_ena_o(enaA), .bram_wea_o(weaA), .bram_dina_o(dinaA),
    .bram_douta_i(doutA), .pix_o(pixA), .pix_valid_o(validA), .underrun_o(undA)
  );

  vga_line_fetch #(
    .RAM_WIDTH(18), .RAM_DEPTH(1024), .PIX_WIDTH(18), .FRAME_WORDS(FW), .FIFO_DEPTH(4)
  ) dutB (
    .clk_i(clk), .rstn_i(rstn), .frame_start_i(fs), .pix_req_i(req), .rd_stall_i(stall),
    .bram_addr_o(addrB), .bram_ena_o(enaB), .bram_wea_o(weaB), .bram_dina_o(dinaB),
    .bram_douta_i(doutB), .pix_o(pixB), .pix_valid_o(validB), .underrun_o(undB)
  );

  // Pixel k of word w in instance A is (6w+k+1) mod 8. Word 0 therefore
  // unpacks to 1..6 and word 1 to 7,0,1,2,3,4.
  function automatic logic [17:0] wordA(input int a);
    logic [17:0] w;
    w = '0;
    for (int k = 0; k < 6; k++) w[k*3 +: 3] = 3'((a * 6 + k + 1) % 8);
    return w;
  endfunction

  function automatic logic [17:0] wordB(input int a);
    return 18'(a * 1111 + 5);
  endfunction

  function automatic int pixelOf(input int inst, input int w, input int k);
    if (inst == 0) return (w * 6 + k + 1) % 8;
    return int'(wordB(w));
  endfunction

  // BRAM models: registered read data, one cycle after the enable.
  always @(posedge clk) begin
    if (enaA) doutA <= wordA(int'(addrA));
    if (enaB) doutB <= wordB(int'(addrB));
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mActive[i] = 0; mRun[i] = 0; mCnt[i] = 0; mInfl[i] = 0; mNext[i] = 0;
      mHead[i] = 0; mIdx[i] = 0; mUnd[i] = 0; mPix[i] = 0; mValid[i] = 0;
    end
  endtask

  // Compare one instance against the model, then advance the model across
  // the coming rising edge using the inputs that are stable now.
  task automatic compareInstance(input int i);
    string tag;
    int    ppw, expEna, pop, newRun;
    int    aEna, aAddr, aPix, aValid, aUnd, aWea, aDina;
    tag    = (i == 0) ? "A" : "B";
    ppw    = (i == 0) ? 6 : 1;
    aEna   = (i == 0) ? int'(enaA)   : int'(enaB);
    aAddr  = (i == 0) ? int'(addrA)  : int'(addrB);
    aPix   = (i == 0) ? int'(pixA)   : int'(pixB);
    aValid = (i == 0) ? int'(validA) : int'(validB);
    aUnd   = (i == 0) ? int'(undA)   : int'(undB);
    aWea   = (i == 0) ? int'(weaA)   : int'(weaB);
    aDina  = (i == 0) ? int'(dinaA)  : int'(dinaB);
    expEna = (rstn && mActive[i] != 0 && !stall && !fs && (mCnt[i] + mInfl[i] < 4)) ? 1 : 0;
    checkOutput({tag, "_ena"}, aEna, expEna);
    if (expEna != 0) checkOutput({tag, "_addr"}, aAddr, mNext[i]);
    checkOutput({tag, "_pix"}, aPix, mPix[i]);
    checkOutput({tag, "_valid"}, aValid, mValid[i]);
    checkOutput({tag, "_underrun"}, aUnd, mUnd[i]);
    checkOutput({tag, "_wea"}, aWea, 0);
    checkOutput({tag, "_dina"}, aDina, 0);
    if (!rstn) return;
    if (fs) begin
      mActive[i] = 1; mRun[i] = 0; mCnt[i] = 0; mInfl[i] = 0; mNext[i] = 0;
      mHead[i] = 0; mIdx[i] = 0; mUnd[i] = 0; mPix[i] = 0; mValid[i] = 0;
      return;
    end
    pop = 0;
    if (mRun[i] != 0 && req && mCnt[i] > 0) begin
      mPix[i]   = pixelOf(i, mHead[i], mIdx[i]);
      mValid[i] = 1;
      if (mIdx[i] == ppw - 1) begin
        pop      = 1;
        mIdx[i]  = 0;
        mHead[i] = (mHead[i] + 1) % FW;
      end else begin
        mIdx[i] = mIdx[i] + 1;
      end
    end else begin
      mPix[i]   = 0;
      mValid[i] = 0;
      if (mRun[i] != 0 && req) mUnd[i] = 1;
    end
    newRun  = (mRun[i] != 0 || (mActive[i] != 0 && mCnt[i] == 4)) ? 1 : 0;
    mCnt[i] = mCnt[i] + mInfl[i] - pop;
    mInfl[i] = expEna;
    if (expEna != 0) mNext[i] = (mNext[i] + 1) % FW;
    mRun[i] = newRun;
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) modelReset();
    for (int i = 0; i < 2; i++) compareInstance(i);
  end

  // Inputs change just after the rising edge. The task returns on the
  // following falling edge, where the outputs for this cycle can be inspected.
  task automatic applyStimulus(input logic f, input logic r, input logic s);
    @(posedge clk);
    #1;
    fs = f; req = r; stall = s;
    @(negedge clk);
  endtask

  initial begin
    int expSeq [12];
    int lastIssued, sawWrap, cntA, cntB, found;
    expSeq = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4};
    modelReset();
    rstn = 1'b0; fs = 1'b0; req = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);

    // Out of reset nothing is fetched until a frame starts.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0);
      checkOutput("lit_idle_ena", int'(enaA), 0);
    end
    checkOutput("lit_idle_pix", int'(pixA), 0);

    // Frame start: four back-to-back reads at 0..3, then the first 12 pixels.
    applyStimulus(1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 0, 0);
      checkOutput("lit_pref_ena", int'(enaA), 1);
      checkOutput("lit_pref_addr", int'(addrA), j);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      applyStimulus(0, 1, 0);
      if (j > 0) begin
        checkOutput("lit_pix_seq", int'(pixA), expSeq[j-1]);
        checkOutput("lit_pix_valid", int'(validA), 1);
      end
    end
    applyStimulus(0, 0, 0);
    checkOutput("lit_pix_seq", int'(pixA), expSeq[11]);

    // Continuous requests across the frame wrap. After address 7 comes 0.
    // 72 requests leave instance A at the start of a word.
    lastIssued = -1; sawWrap = 0; cntB = 0;
    for (int j = 0; j < 72; j++) begin
      applyStimulus(0, 1, 0);
      if (validB) cntB++;
      if (enaA) begin
        if (lastIssued == 7) begin
          checkOutput("lit_wrap_addr", int'(addrA), 0);
          sawWrap = 1;
        end
        lastIssued = int'(addrA);
      end
    end
    checkOutput("lit_wrap_seen", sawWrap, 1);
    checkOutput("lit_B_stream_count", cntB, 71);

    // Underrun: fill the FIFO, then stall reads while requesting. A full FIFO
    // yields exactly four words of pixels before the underrun.
    for (int j = 0; j < 10; j++) applyStimulus(0, 0, 0);
    cntA = 0; cntB = 0;
    for (int j = 0; j < 40; j++) begin
      applyStimulus(0, 1, 1);
      if (validA) cntA++;
      if (validB) cntB++;
    end
    checkOutput("lit_underrun_pixA", cntA, 24);
    checkOutput("lit_underrun_pixB", cntB, 4);
    checkOutput("lit_underrun_A", int'(undA), 1);
    checkOutput("lit_underrun_B", int'(undB), 1);
    cntA = 0;
    for (int j = 0; j < 20; j++) begin
      applyStimulus(0, 1, 0);
      if (validA) cntA++;
    end
    checkOutput("lit_resume_any", (cntA > 0) ? 1 : 0, 1);
    checkOutput("lit_underrun_sticky", int'(undA), 1);

    // Frame start right after a read of address 5. That word is dropped,
    // and the new frame begins with word 0 pixel 0.
    found = 0;
    for (int j = 0; j < 200 && found == 0; j++) begin
      applyStimulus(0, 1, 0);
      if (enaA && addrA == 10'd5) found = 1;
    end
    checkOutput("lit_addr5_found", found, 1);
    applyStimulus(1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 0, 0);
      if (j == 0) checkOutput("lit_flush_underrun", int'(undA), 0);
      checkOutput("lit_flush_ena", int'(enaA), 1);
      checkOutput("lit_flush_addr", int'(addrA), j);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("lit_flush_first_valid", int'(validA), 1);
    checkOutput("lit_flush_first_pix", int'(pixA), 1);
    checkOutput("lit_flush_first_pixB", int'(pixB), int'(wordB(0)));

    // One pixel per word on B: pushes and pops coincide over two frames.
    cntB = 0;
    for (int j = 0; j < 20; j++) begin
      applyStimulus(0, 1, 0);
      if (validB) cntB++;
    end
    checkOutput("lit_B_two_frames", cntB, 19);

    // Asynchronous reset in the middle of RUN clears the outputs at once.
    @(posedge clk); #1; rstn = 1'b0;
    #1;
    checkOutput("lit_rst_pix", int'(pixA), 0);
    checkOutput("lit_rst_valid", int'(validA), 0);
    checkOutput("lit_rst_ena", int'(enaA), 0);
    checkOutput("lit_rst_addr", int'(addrA), 0);
    checkOutput("lit_rst_pixB", int'(pixB), 0);
    @(negedge clk);
    @(posedge clk); #1; rstn = 1'b1; req = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(0, 0, 0);
      checkOutput("lit_post_rst_ena", int'(enaA), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
